serial_frame_validator: RTL

// - Parametrised receive-side frame checker for the bit-synchronised serial path.
// - Frame format: start bit (0), DATA_W data bits (MSB first), optional parity, STOP_BITS stop bits (1).
// - Samples SDI on BIT_EN strobes, then reports good frames (data plus pulse) or bad frames (error code).
// - Keeps saturating good/error frame counters for the status block.

---
 rtl/serial_frame_validator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/serial_frame_validator.sv
// Receive-side checker for start/data/[parity]/stop serial frames sampled on BIT_EN strobes.
// Optional parity stage is built only when SFV_PARITY_EN is defined.
module serial_frame_validator #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit_en,
    input  logic              i_sdi,
    input  logic              i_clr_cnt,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_frame_valid,
    output logic              o_frame_err,
    output logic [1:0]        o_err_code,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_good_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam int unsigned BitCntW = $clog2(DATA_W + 1);

`ifdef SFV_PARITY_EN
    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StData, StStop} state_e;
`endif

    state_e              r_state, w_state_d;
    logic [DATA_W-1:0]   r_shreg, w_shreg_d;
    logic [BitCntW-1:0]  r_bit_cnt, w_bit_cnt_d;
    logic [1:0]          r_stop_cnt, w_stop_cnt_d;
    logic                r_stop_err, w_stop_err_d;
    logic                w_par_err_d;
    logic                w_done;
    logic                w_bad;

    logic [DATA_W-1:0]   r_data_out, w_data_out_d;
    logic                r_frame_valid, w_frame_valid_d;
    logic                r_frame_err, w_frame_err_d;
    logic [1:0]          r_err_code, w_err_code_d;
    logic [CNT_W-1:0]    r_good_cnt, w_good_cnt_d;
    logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_d;

`ifdef SFV_PARITY_EN
    logic                r_par_err;
`else
    logic                w_unused_parity_odd;
    assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_shreg_d    = r_shreg;
        w_bit_cnt_d  = r_bit_cnt;
        w_stop_cnt_d = r_stop_cnt;
        w_stop_err_d = r_stop_err;
`ifdef SFV_PARITY_EN
        w_par_err_d  = r_par_err;
`else
        w_par_err_d  = 1'b0;
`endif
        w_done       = 1'b0;

        if (i_bit_en) begin
            unique case (r_state)
                StIdle: begin
                    if (!i_sdi) begin
                        w_state_d    = StData;
                        w_bit_cnt_d  = '0;
                        w_stop_cnt_d = '0;
                        w_stop_err_d = 1'b0;
                        w_par_err_d  = 1'b0;
                    end
                end
                StData: begin
                    w_shreg_d   = {r_shreg[DATA_W-2:0], i_sdi};
                    w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
                    if (r_bit_cnt == BitCntW'(DATA_W - 1)) begin
`ifdef SFV_PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end
                end
`ifdef SFV_PARITY_EN
                StParity: begin
                    w_par_err_d = i_sdi != ((^r_shreg) ^ 1'(PARITY_ODD));
                    w_state_d   = StStop;
                end
`endif
                StStop: begin
                    if (!i_sdi) begin
                        w_stop_err_d = 1'b1;
                    end
                    w_stop_cnt_d = r_stop_cnt + 2'd1;
                    if (r_stop_cnt == 2'(STOP_BITS - 1)) begin
                        w_state_d = StIdle;
                        w_done    = 1'b1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Completion uses the error flags including the bit sampled on this very edge.
    always_comb begin
        w_bad           = w_stop_err_d | w_par_err_d;
        w_frame_valid_d = w_done & ~w_bad;
        w_frame_err_d   = w_done & w_bad;
        w_data_out_d    = w_frame_valid_d ? r_shreg : r_data_out;
        w_err_code_d    = w_done ? {w_par_err_d, w_stop_err_d} : r_err_code;

        w_good_cnt_d = r_good_cnt;
        w_err_cnt_d  = r_err_cnt;
        if (i_clr_cnt) begin
            w_good_cnt_d = '0;
            w_err_cnt_d  = '0;
        end else begin
            if (w_frame_valid_d && (r_good_cnt != {CNT_W{1'b1}})) begin
                w_good_cnt_d = r_good_cnt + CNT_W'(1);
            end
            if (w_frame_err_d && (r_err_cnt != {CNT_W{1'b1}})) begin
                w_err_cnt_d = r_err_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= StIdle;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_stop_cnt    <= '0;
            r_stop_err    <= 1'b0;
            r_data_out    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_code    <= '0;
            r_good_cnt    <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_d;
            r_shreg       <= w_shreg_d;
            r_bit_cnt     <= w_bit_cnt_d;
            r_stop_cnt    <= w_stop_cnt_d;
            r_stop_err    <= w_stop_err_d;
            r_data_out    <= w_data_out_d;
            r_frame_valid <= w_frame_valid_d;
            r_frame_err   <= w_frame_err_d;
            r_err_code    <= w_err_code_d;
            r_good_cnt    <= w_good_cnt_d;
            r_err_cnt     <= w_err_cnt_d;
        end
    end

`ifdef SFV_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_d;
        end
    end
`endif

    assign o_data_out    = r_data_out;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_err   = r_frame_err;
    assign o_err_code    = r_err_code;
    assign o_busy        = (r_state != StIdle);
    assign o_good_cnt    = r_good_cnt;
    assign o_err_cnt     = r_err_cnt;

endmodule
